dcbarb_rr_arb: RTL and testbench

//  Round-robin burst arbiter that produces the registered one-hot dcbarb_grant

---
 rtl/dcbarb_rr_arb_if.sv | 34 +++
 rtl/dcbarb_rr_arb.sv | 146 ++++++++++++++
 tb/tb_dcbarb_rr_arb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dcbarb_rr_arb_if.sv
// Handshake bundle between the TCQ occupancy/pop side and the round-robin burst arbiter.
interface dcbarb_rr_arb_if #(
    parameter int unsigned N = 8
);
    logic         arb_en;
    logic [N-1:0] tcqs_req;
    logic [N-1:0] tcqs_last;
    logic         dcb_ready;
    logic [N-1:0] dcbarb_grant;
    logic         dcbarb_busy;
    logic         err;

    // Requester / pop-stage side
    modport master (
        output arb_en,
        output tcqs_req,
        output tcqs_last,
        output dcb_ready,
        input  dcbarb_grant,
        input  dcbarb_busy,
        input  err
    );

    // Arbiter side
    modport slave (
        input  arb_en,
        input  tcqs_req,
        input  tcqs_last,
        input  dcb_ready,
        output dcbarb_grant,
        output dcbarb_busy,
        output err
    );
endinterface

// File: rtl/dcbarb_rr_arb.sv
// Round-robin burst arbiter: grants one non-empty TCQ for up to MAX_BURST pops,
// then rotates priority past the winner. Grant, busy and err are registered.
module dcbarb_rr_arb #(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    dcbarb_rr_arb_if.slave  bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [IW:0]     pick_idle;
    logic [IW:0]     pick_next;
    logic [N-1:0]    keep_mask;
    logic [IW-1:0]   win_nxt;
    logic            burst_end;

    // (i + 1) mod N for a requester index
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (i == IW'(N - 1)) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    // First set bit scanning start, start+1, .. wrapping; MSB of result = found
    function automatic logic [IW:0] pick(input logic [N-1:0] req, input logic [IW-1:0] start);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        logic          found;
        res   = '0;
        idx   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                res   = {1'b1, idx};
            end
            idx = wrap_inc(idx);
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        return N'(1) << i;
    endfunction

    // Candidate selection for a fresh grant and for a back-to-back regrant
    assign win_nxt   = wrap_inc(win_q);
    assign keep_mask = bus.tcqs_req & ~(N'(bus.tcqs_last[win_q]) << win_q);
    assign pick_idle = pick(bus.tcqs_req, ptr_q);
    assign pick_next = pick(keep_mask, win_nxt);
    assign burst_end = (cnt_q == CW'(MAX_BURST - 1)) || bus.tcqs_last[win_q];

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (bus.arb_en && (|bus.tcqs_req)) begin
                    grant_d = onehot(pick_idle[IW-1:0]);
                    win_d   = pick_idle[IW-1:0];
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.dcb_ready) begin
                    if (burst_end) begin
                        ptr_d = win_nxt;
                        cnt_d = '0;
                        if (bus.arb_en && pick_next[IW]) begin
                            grant_d = onehot(pick_next[IW-1:0]);
                            win_d   = pick_next[IW-1:0];
                        end else begin
                            grant_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (!bus.tcqs_req[win_q]) begin
                    // Winner emptied without being popped: flag and release
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = win_nxt;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = |grant_d;
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            win_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.dcbarb_grant = grant_q;
    assign bus.dcbarb_busy  = busy_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_dcbarb_rr_arb.sv
// Bench for dcbarb_rr_arb: directed scenarios plus random traffic against a pop-counting model.
module tb_dcbarb_rr_arb;
    localparam int unsigned N  = 8;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcbarb_rr_arb_if #(.N(N)) bus ();

    dcbarb_rr_arb #(.N(N), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current winner (-1 = none), pops taken in this burst, rotation pointer
    int   m_w;
    int   m_pops;
    int   m_ptr;
    logic m_err;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < int'(N); k++) begin
            int idx;
            idx = (start + k) % int'(N);
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_w >= 0) g[m_w] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_w    = -1;
        m_pops = 0;
        m_ptr  = 0;
        m_err  = 1'b0;
    endtask

    // Apply one clock edge of the arbitration rules to the model
    task automatic model_step();
        logic [N-1:0] req;
        logic [N-1:0] cand;
        req = bus.tcqs_req;
        if (m_w < 0) begin
            if (bus.arb_en && req != '0) begin
                m_w    = pick(req, m_ptr);
                m_pops = 0;
            end
        end else if (bus.dcb_ready) begin
            if (m_pops + 1 == int'(MB) || bus.tcqs_last[m_w]) begin
                m_ptr = (m_w + 1) % int'(N);
                cand  = req;
                if (bus.tcqs_last[m_w]) cand[m_w] = 1'b0;
                if (bus.arb_en && cand != '0) begin
                    m_w    = pick(cand, m_ptr);
                    m_pops = 0;
                end else begin
                    m_w    = -1;
                    m_pops = 0;
                end
            end else begin
                m_pops = m_pops + 1;
            end
        end else if (!req[m_w]) begin
            m_err  = 1'b1;
            m_ptr  = (m_w + 1) % int'(N);
            m_w    = -1;
            m_pops = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [N-1:0] req, input logic [N-1:0] last, input logic rdy);
        bus.arb_en    = en;
        bus.tcqs_req  = req;
        bus.tcqs_last = last;
        bus.dcb_ready = rdy;
    endtask

    // One clock: advance model at the edge, then compare all outputs just after it
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk({tag, ":grant"}, 32'(bus.dcbarb_grant), 32'(exp_grant()));
        chk({tag, ":busy"}, 32'(bus.dcbarb_busy), 32'(exp_grant() != '0));
        chk({tag, ":err"}, 32'(bus.err), 32'(m_err));
        chk({tag, ":onehot"}, 32'($onehot0(bus.dcbarb_grant)), 32'd1);
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ":rst_grant"}, 32'(bus.dcbarb_grant), 32'd0);
        chk({tag, ":rst_busy"}, 32'(bus.dcbarb_busy), 32'd0);
        chk({tag, ":rst_err"}, 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] t2_exp [9];
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        model_reset();
        #2;
        do_reset("init");

        // 1: no requests -> stays idle
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        repeat (6) tick("t1");
        chk("t1:idle_grant", 32'(bus.dcbarb_grant), 32'h0);

        // 2: two requesters alternate in bursts of MB with no bubble
        t2_exp = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h20, 8'h20, 8'h20, 8'h20, 8'h04};
        drive(1'b1, 8'h24, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick("t2");
            chk("t2:seq", 32'(bus.dcbarb_grant), 32'(t2_exp[i]));
        end
        drive(1'b0, 8'h24, 8'h00, 1'b1);
        repeat (4) tick("t2_drain");
        chk("t2:drained", 32'(bus.dcbarb_grant), 32'h0);

        // 3: single requester, last on second pop -> 2-cycle grant, pointer moves to 1
        drive(1'b1, 8'h01, 8'h00, 1'b1);
        tick("t3");
        chk("t3:g1", 32'(bus.dcbarb_grant), 32'h01);
        tick("t3");
        chk("t3:g2", 32'(bus.dcbarb_grant), 32'h01);
        drive(1'b1, 8'h01, 8'h01, 1'b1);
        tick("t3");
        chk("t3:end", 32'(bus.dcbarb_grant), 32'h00);
        drive(1'b1, 8'h03, 8'h00, 1'b0);
        tick("t3");
        chk("t3:ptr1", 32'(bus.dcbarb_grant), 32'h02);
        drive(1'b0, 8'h03, 8'h02, 1'b1);
        tick("t3_drain");
        chk("t3:drained", 32'(bus.dcbarb_grant), 32'h00);

        // 4: stall holds grant, then winner empties without pop -> sticky err
        drive(1'b1, 8'h10, 8'h00, 1'b0);
        tick("t4");
        chk("t4:grant", 32'(bus.dcbarb_grant), 32'h10);
        repeat (5) begin
            tick("t4_stall");
            chk("t4:hold", 32'(bus.dcbarb_grant), 32'h10);
        end
        drive(1'b1, 8'h00, 8'h00, 1'b0);
        tick("t4_viol");
        chk("t4:err", 32'(bus.err), 32'h1);
        chk("t4:drop", 32'(bus.dcbarb_grant), 32'h00);
        repeat (3) tick("t4_sticky");
        chk("t4:err_sticky", 32'(bus.err), 32'h1);
        do_reset("t4_rst");

        // 5: arb_en drops mid-burst on requester 1 -> burst completes, no regrant
        drive(1'b1, 8'hFF, 8'h00, 1'b1);
        repeat (5) tick("t5");
        chk("t5:at02", 32'(bus.dcbarb_grant), 32'h02);
        drive(1'b0, 8'hFF, 8'h00, 1'b1);
        repeat (3) tick("t5_finish");
        chk("t5:still02", 32'(bus.dcbarb_grant), 32'h02);
        tick("t5_end");
        chk("t5:idle", 32'(bus.dcbarb_grant), 32'h00);
        tick("t5_off");
        drive(1'b1, 8'hFF, 8'h00, 1'b0);
        tick("t5_on");
        chk("t5:next04", 32'(bus.dcbarb_grant), 32'h04);

        // 6: reset during grant clears immediately; fresh grant one clock after release
        drive(1'b1, 8'h80, 8'h00, 1'b0);
        do_reset("t6");
        tick("t6_after");
        chk("t6:g80", 32'(bus.dcbarb_grant), 32'h80);

        // Random traffic; winner usually keeps its request so violations stay rare
        for (int seg = 0; seg < 4; seg++) begin
            do_reset("rnd_rst");
            for (int c = 0; c < 150; c++) begin
                logic [N-1:0] r;
                logic [N-1:0] l;
                r = N'($urandom);
                if ($urandom_range(0, 9) == 0) r = '0;
                if (m_w >= 0 && $urandom_range(0, 24) != 0) r[m_w] = 1'b1;
                l = N'($urandom & $urandom & $urandom);
                drive(($urandom_range(0, 7) != 0), r, l, ($urandom_range(0, 3) != 0));
                tick("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
